pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
Parametrised inter-stage pipeline buffer. It is the successor to the single-entry decode/execute register and sits between any two pipeline stages (D->E, E->M). It holds up to DEPTH in-flight instruction payloads, each tagged with a ROB id, and moves them with a valid/ready handshake instead of a global stall. It supports a single-cycle flush on mispredict or exception and exports occupancy status for stall and fetch-throttling logic.

Parameters:
DATA_WIDTH, 128, packed payload width (instr type, pc, opcode, funct7/3, s1, s2, immediate), >=1
ROB_ENTRY_WIDTH, 4, ROB id tag width, >=1
DEPTH, 2, number of entries, >=1, need not be a power of two
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset; 0 = reset asserted
flush  input  1  synchronous kill of all entries
in_valid  input  1  upstream offers a payload
in_ready  output  1  buffer can accept this cycle
in_data  input  DATA_WIDTH  upstream payload
in_rob_id  input  ROB_ENTRY_WIDTH  upstream ROB tag
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head this cycle
out_data  output  DATA_WIDTH  head payload
out_rob_id  output  ROB_ENTRY_WIDTH  head ROB tag
count  output  CNT_WIDTH  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Storage: circular array of DEPTH {data, rob_id} entries, with wr_ptr, rd_ptr and count registers.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = !full || out_ready. This is the only combinational input->output path and is intentional: a full buffer accepts when the head drains in the same cycle.
- out_valid = !empty. out_data and out_rob_id = entry[rd_ptr], driven from storage only. There is no same-cycle in->out bypass.
- Latency: minimum 1 cycle. A payload pushed at edge N is visible on out_* after edge N.
- Throughput: 1 payload/cycle sustained for any DEPTH >= 1 while out_ready = 1.
- Pointer update: on push, wr_ptr advances; on pop, rd_ptr advances. Each wraps DEPTH-1 -> 0 explicitly (no modulo-2^n reliance).
- count update: push-only +1; pop-only -1; push and pop together: unchanged; neither: unchanged.
- Ordering: strict FIFO. ROB tags leave in arrival order.
- Priority each edge: reset (low) > flush > push/pop.
- Reset (reset = 0 at edge): count = 0, wr_ptr = rd_ptr = 0, all entry data and rob_id cleared to 0. After reset: out_valid = 0, out_data = 0, out_rob_id = 0, empty = 1, full = 0, in_ready = 1.
- Reset mid-traffic: all entries discarded. Any push or pop in that cycle has no effect.
- Flush (flush = 1, reset = 1): count = 0 and pointers = 0 at the edge. A push in the same cycle is dropped. A pop in the same cycle is meaningless because the entry is killed anyway. Entry contents are left stale and are unobservable because out_valid = 0.
- in_ready is not gated by flush. Upstream must squash its own valid on flush.
- Full, no pop: in_ready = 0. in_data is ignored and no state changes.
- Empty with a push in the same cycle: the entry is stored, out_valid rises next cycle, and no pop occurs.
- in_valid = 0 never writes storage, even when in_ready = 1.
- DEPTH = 1: behaves as a single pipeline register with handshake. Back-to-back transfers at full rate when out_ready = 1.
- X-safety: out_data is never X after reset, regardless of in_data.

Test Plan:
1. DEPTH=2, reset low 2 cycles, then high -> out_valid=0, out_data=0, count=0, empty=1, in_ready=1.
2. DEPTH=2, out_ready=0, push rob_id 1,2,3 on consecutive cycles -> 1 and 2 accepted, count=2, full=1, in_ready=0 on the third cycle, rob 3 not stored; out_rob_id=1 held.
3. DEPTH=3, out_ready=1, push rob_id 0..9 back-to-back -> out_rob_id 0..9 in order, each 1 cycle after its push, count steady at 1, no bubbles, pointers wrap correctly.
4. DEPTH=2 full (rob 4,5), out_ready=1 and in_valid=1 (rob 6) in the same cycle -> in_ready=1, next cycle out_rob_id=5, count=2, then 6 follows.
5. DEPTH=4 holding 3 entries, flush=1 with in_valid=1 (rob 7) -> next cycle count=0, out_valid=0; the following push of rob 8 appears as first output.
6. DEPTH=4 holding 2 entries, reset=0 and flush=0 with push and pop active -> next cycle count=0, out_data=0, out_rob_id=0; after release a push of rob 3 emerges alone.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// Inter-stage pipeline buffer: DEPTH-entry FIFO of {rob_id, payload}
// with valid/ready handshake, single-cycle flush and occupancy status.
module pipe_stage_fifo #(
  parameter  int DATA_WIDTH      = 128,
  parameter  int ROB_ENTRY_WIDTH = 4,
  parameter  int DEPTH           = 2,
  localparam int CNT_WIDTH       = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
  output logic [CNT_WIDTH-1:0]       count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    logic [DATA_WIDTH-1:0]      data;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push;
  logic                 pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (count_q == CNT_WIDTH'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  // A full buffer still accepts when the head drains this cycle.
  assign in_ready   = !full || out_ready;
  assign out_valid  = !empty;
  assign out_data   = mem_q[rd_ptr_q].data;
  assign out_rob_id = mem_q[rd_ptr_q].rob_id;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{rob_id: in_rob_id, data: in_data};
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = nxt(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: DEPTH 2/3/4 instances share stimulus and
// are compared each cycle against queue scoreboards plus directed checks.
module tb_pipe_stage_fifo;

  localparam int DW = 32;
  localparam int RW = 4;

  typedef logic [RW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_rob_id = '0;

  logic [2:0]         rdy, ov, fl, em;
  logic [2:0][DW-1:0] od;
  logic [2:0][RW-1:0] orob;
  logic [1:0]         c2, c3;
  logic [2:0]         c4;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int seq    = 0;

  ent_t q2[$];
  ent_t q3[$];
  ent_t q4[$];

  always #5 clk = ~clk;

  pipe_stage_fifo #(.DATA_WIDTH(DW), .ROB_ENTRY_WIDTH(RW), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_rob_id(in_rob_id),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_rob_id(orob[0]),
    .count(c2), .full(fl[0]), .empty(em[0])
  );

  pipe_stage_fifo #(.DATA_WIDTH(DW), .ROB_ENTRY_WIDTH(RW), .DEPTH(3)) u3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_rob_id(in_rob_id),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_rob_id(orob[1]),
    .count(c3), .full(fl[1]), .empty(em[1])
  );

  pipe_stage_fifo #(.DATA_WIDTH(DW), .ROB_ENTRY_WIDTH(RW), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data), .in_rob_id(in_rob_id),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_rob_id(orob[2]),
    .count(c4), .full(fl[2]), .empty(em[2])
  );

  // Reference queues: accept when not full or head drains; pop head first.
  always @(posedge clk) begin
    automatic int n2 = q2.size();
    automatic int n3 = q3.size();
    automatic int n4 = q4.size();
    if (!reset || flush) begin
      q2.delete();
      q3.delete();
      q4.delete();
    end else begin
      if (n2 > 0 && out_ready) void'(q2.pop_front());
      if (in_valid && (n2 < 2 || out_ready)) q2.push_back({in_rob_id, in_data});
      if (n3 > 0 && out_ready) void'(q3.pop_front());
      if (in_valid && (n3 < 3 || out_ready)) q3.push_back({in_rob_id, in_data});
      if (n4 > 0 && out_ready) void'(q4.pop_front());
      if (in_valid && (n4 < 4 || out_ready)) q4.push_back({in_rob_id, in_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ready();
    chk("u2.in_ready", rdy[0], q2.size() < 2 || out_ready);
    chk("u3.in_ready", rdy[1], q3.size() < 3 || out_ready);
    chk("u4.in_ready", rdy[2], q4.size() < 4 || out_ready);
  endtask

  task automatic chk_out();
    chk("u2.out_valid", ov[0], q2.size() != 0);
    chk("u2.count", c2, q2.size());
    chk("u2.full", fl[0], q2.size() == 2);
    chk("u2.empty", em[0], q2.size() == 0);
    if (q2.size() != 0) chk("u2.head", {orob[0], od[0]}, q2[0]);
    chk("u3.out_valid", ov[1], q3.size() != 0);
    chk("u3.count", c3, q3.size());
    chk("u3.full", fl[1], q3.size() == 3);
    chk("u3.empty", em[1], q3.size() == 0);
    if (q3.size() != 0) chk("u3.head", {orob[1], od[1]}, q3[0]);
    chk("u4.out_valid", ov[2], q4.size() != 0);
    chk("u4.count", c4, q4.size());
    chk("u4.full", fl[2], q4.size() == 4);
    chk("u4.empty", em[2], q4.size() == 0);
    if (q4.size() != 0) chk("u4.head", {orob[2], od[2]}, q4[0]);
  endtask

  task automatic tick();
    #1 chk_ready();
    @(posedge clk);
    #1 chk_out();
  endtask

  task automatic drive(input int rob);
    in_valid  = 1'b1;
    in_rob_id = RW'(rob);
    in_data   = 32'hD000_0000 + DW'(seq);
    seq++;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset state
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    chk_out();
    chk("t1.out_valid", ov[0], 0);
    chk("t1.out_data", od[0], 0);
    chk("t1.out_rob_id", orob[0], 0);
    chk("t1.count", c2, 0);
    chk("t1.empty", em[0], 1);
    chk("t1.full", fl[0], 0);
    chk("t1.in_ready", rdy[0], 1);
    chk("t1.out_data_d4", od[2], 0);

    // 2: fill DEPTH=2 without draining
    out_ready = 1'b0;
    drive(1); tick();
    drive(2); tick();
    drive(3);
    #1 chk("t2.in_ready_full", rdy[0], 0);
    tick();
    in_valid = 1'b0;
    chk("t2.count", c2, 2);
    chk("t2.full", fl[0], 1);
    chk("t2.head", orob[0], 1);
    tick();
    chk("t2.head_held", orob[0], 1);
    chk("t2.count_d4", c4, 3);

    // 3: DEPTH=3 streaming with wrap
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(k);
      tick();
      chk("t3.rob", orob[1], k);
      chk("t3.count", c3, 1);
      chk("t3.valid", ov[1], 1);
    end
    in_valid = 1'b0;
    tick();
    chk("t3.drained", em[1], 1);

    // 4: full DEPTH=2 with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    drive(4); tick();
    drive(5); tick();
    out_ready = 1'b1;
    drive(6);
    #1 chk("t4.in_ready", rdy[0], 1);
    tick();
    in_valid = 1'b0;
    chk("t4.head5", orob[0], 5);
    chk("t4.count2", c2, 2);
    tick();
    chk("t4.head6", orob[0], 6);
    chk("t4.count1", c2, 1);
    out_ready = 1'b0;

    // 5: flush drops a same-cycle push
    do_reset();
    drive(1); tick();
    drive(2); tick();
    drive(3); tick();
    chk("t5.count3", c4, 3);
    flush = 1'b1;
    drive(7);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t5.count0", c4, 0);
    chk("t5.valid0", ov[2], 0);
    drive(8);
    tick();
    in_valid = 1'b0;
    chk("t5.head8", orob[2], 8);
    chk("t5.valid1", ov[2], 1);

    // 6: reset mid-traffic with push and pop active
    do_reset();
    drive(1); tick();
    drive(2); tick();
    chk("t6.count2", c4, 2);
    reset     = 1'b0;
    out_ready = 1'b1;
    drive(9);
    tick();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t6.count0", c4, 0);
    chk("t6.out_data0", od[2], 0);
    chk("t6.out_rob0", orob[2], 0);
    chk("t6.valid0", ov[2], 0);
    drive(3);
    tick();
    in_valid = 1'b0;
    chk("t6.head3", orob[2], 3);
    chk("t6.count1", c4, 1);
    out_ready = 1'b1;
    tick();
    chk("t6.alone", em[2], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
